// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch controller: command FSM, tick prescaler and a 4-digit BCD counter
// chain cascaded through clock enables, with split-time display freeze.
module bcd_stopwatch_ctrl #(
    parameter int PRESCALE = 10
) (
    input  logic        CLK,
    input  logic        CLRN,
    input  logic        START_STOP,
    input  logic        LAP,
    input  logic        ZERO,
    output logic [15:0] CNT,
    output logic [15:0] Q,
    output logic        RUN,
    output logic        SPLIT_ON,
    output logic        OVF
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_SPLIT = 2'd3
    } state_t;

    state_t        state_r;
    logic          run_r;
    logic          split_r;
    logic [PW-1:0] prescale_r;
    logic [15:0]   cnt_r;
    logic [15:0]   latch_r;
    logic          ovf_r;

    logic          counting_s;
    logic          tick_s;
    logic          zero_acc_s;
    logic          lap_cap_s;
    logic          ovf_s;
    logic [3:0]    ce_s;
    logic [15:0]   cnt_next_s;

    // Single BCD digit increment; anything at or above 9 folds back to 0.
    function automatic logic [3:0] bcd_step(input logic [3:0] d);
        logic [3:0] r;
        if (d >= 4'd9) begin
            r = 4'd0;
        end else begin
            r = d + 4'd1;
        end
        return r;
    endfunction

    // Tick generation, command qualification and the digit enable chain.
    always_comb begin
        counting_s = (state_r == S_RUN) || (state_r == S_SPLIT);
        tick_s     = counting_s && (prescale_r == PS_LAST);
        zero_acc_s = (state_r == S_PAUSE) && ZERO && !START_STOP;
        lap_cap_s  = (state_r == S_RUN) && LAP && !START_STOP;
        ce_s       = 4'b0000;
        cnt_next_s = cnt_r;
        ce_s[0]    = tick_s;
        for (int k = 1; k < 4; k++) begin
            ce_s[k] = ce_s[k-1] && (cnt_r[4*(k-1) +: 4] == 4'd9);
        end
        for (int k = 0; k < 4; k++) begin
            if (ce_s[k]) begin
                cnt_next_s[4*k +: 4] = bcd_step(cnt_r[4*k +: 4]);
            end else begin
                cnt_next_s[4*k +: 4] = cnt_r[4*k +: 4];
            end
        end
        ovf_s = ce_s[3] && (cnt_r[15:12] == 4'd9);
    end

    // Command FSM with RUN/SPLIT_ON decoded into registers alongside the state.
    always_ff @(posedge CLK) begin
        if (!CLRN) begin
            state_r <= S_IDLE;
            run_r   <= 1'b0;
            split_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (START_STOP) begin
                        state_r <= S_RUN;
                        run_r   <= 1'b1;
                        split_r <= 1'b0;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (START_STOP) begin
                        state_r <= S_PAUSE;
                        run_r   <= 1'b0;
                        split_r <= 1'b0;
                    end else if (LAP) begin
                        state_r <= S_SPLIT;
                        run_r   <= 1'b1;
                        split_r <= 1'b1;
                    end else begin
                        state_r <= S_RUN;
                    end
                end
                S_SPLIT: begin
                    if (START_STOP) begin
                        state_r <= S_PAUSE;
                        run_r   <= 1'b0;
                        split_r <= 1'b0;
                    end else if (LAP) begin
                        state_r <= S_RUN;
                        run_r   <= 1'b1;
                        split_r <= 1'b0;
                    end else begin
                        state_r <= S_SPLIT;
                    end
                end
                S_PAUSE: begin
                    if (START_STOP) begin
                        state_r <= S_RUN;
                        run_r   <= 1'b1;
                        split_r <= 1'b0;
                    end else if (ZERO) begin
                        state_r <= S_IDLE;
                        run_r   <= 1'b0;
                        split_r <= 1'b0;
                    end else begin
                        state_r <= S_PAUSE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    run_r   <= 1'b0;
                    split_r <= 1'b0;
                end
            endcase
        end
    end

    // Prescaler: advances only while counting, holds its phase across a pause.
    always_ff @(posedge CLK) begin
        if (!CLRN) begin
            prescale_r <= '0;
        end else if (zero_acc_s) begin
            prescale_r <= '0;
        end else if (counting_s) begin
            if (prescale_r == PS_LAST) begin
                prescale_r <= '0;
            end else begin
                prescale_r <= prescale_r + PW'(1);
            end
        end else begin
            prescale_r <= prescale_r;
        end
    end

    // Count, split latch and sticky overflow.
    always_ff @(posedge CLK) begin
        if (!CLRN) begin
            cnt_r   <= 16'h0000;
            latch_r <= 16'h0000;
            ovf_r   <= 1'b0;
        end else begin
            if (zero_acc_s) begin
                cnt_r <= 16'h0000;
                ovf_r <= 1'b0;
            end else begin
                cnt_r <= cnt_next_s;
                ovf_r <= ovf_r | ovf_s;
            end
            if (lap_cap_s) begin
                latch_r <= cnt_r;
            end else begin
                latch_r <= latch_r;
            end
        end
    end

    assign CNT      = cnt_r;
    assign Q        = (state_r == S_SPLIT) ? latch_r : cnt_r;
    assign RUN      = run_r;
    assign SPLIT_ON = split_r;
    assign OVF      = ovf_r;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Scoreboard bench for bcd_stopwatch_ctrl: one instance at PRESCALE=10 and
// one at PRESCALE=1 share the clock and reset.
module tb_bcd_stopwatch_ctrl;

    logic        CLK = 1'b0;
    logic        CLRN = 1'b0;
    logic        ss10 = 1'b0, lap10 = 1'b0, zero10 = 1'b0;
    logic        ss1 = 1'b0, lap1 = 1'b0, zero1 = 1'b0;
    logic [15:0] cnt10, q10, cnt1, q1;
    logic        run10, split10, ovf10, run1, split1, ovf1;

    typedef struct {
        string       name;
        logic [34:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    logic [34:0] obs_q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 CLK = ~CLK;

    bcd_stopwatch_ctrl #(.PRESCALE(10)) u_p10 (
        .CLK(CLK), .CLRN(CLRN), .START_STOP(ss10), .LAP(lap10), .ZERO(zero10),
        .CNT(cnt10), .Q(q10), .RUN(run10), .SPLIT_ON(split10), .OVF(ovf10)
    );

    bcd_stopwatch_ctrl #(.PRESCALE(1)) u_p1 (
        .CLK(CLK), .CLRN(CLRN), .START_STOP(ss1), .LAP(lap1), .ZERO(zero1),
        .CNT(cnt1), .Q(q1), .RUN(run1), .SPLIT_ON(split1), .OVF(ovf1)
    );

    function automatic logic [34:0] pack(input logic [15:0] c, input logic [15:0] q,
                                         input logic r, input logic s, input logic o);
        return {c, q, r, s, o};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic pulse10(input logic s, input logic l, input logic z);
        ss10 = s; lap10 = l; zero10 = z;
        cyc(1);
        ss10 = 1'b0; lap10 = 1'b0; zero10 = 1'b0;
    endtask

    task automatic pulse1(input logic s, input logic l, input logic z);
        ss1 = s; lap1 = l; zero1 = z;
        cyc(1);
        ss1 = 1'b0; lap1 = 1'b0; zero1 = 1'b0;
    endtask

    task automatic expect_push(input string n, input logic [34:0] v);
        exp_t e;
        e.name = n;
        e.exp  = v;
        sb_q.push_back(e);
    endtask

    task automatic sample10();
        obs_q.push_back({cnt10, q10, run10, split10, ovf10});
    endtask

    task automatic sample1();
        obs_q.push_back({cnt1, q1, run1, split1, ovf1});
    endtask

    task automatic test_reset();
        CLRN = 1'b0;
        expect_push("reset_p10", pack(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0));
        expect_push("reset_p1",  pack(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0));
        cyc(2);
        sample10(); sample1();
        CLRN = 1'b1;
        while (sb_q.size() > 0) begin
            exp_t e; logic [34:0] o;
            e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e.exp) begin
                errors++;
                $display("FAIL %s: got cnt=%h q=%h run=%b split=%b ovf=%b, expected cnt=%h q=%h run=%b split=%b ovf=%b",
                         e.name, o[34:19], o[18:3], o[2], o[1], o[0], e.exp[34:19], e.exp[18:3], e.exp[2], e.exp[1], e.exp[0]);
            end
        end
    endtask

    task automatic test_first_tick();
        expect_push("start_run", pack(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0));
        pulse10(1'b1, 1'b0, 1'b0); sample10();
        expect_push("no_tick_edge8", pack(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0));
        cyc(8); sample10();
        expect_push("no_tick_edge9", pack(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0));
        cyc(1); sample10();
        expect_push("first_tick_edge10", pack(16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0));
        cyc(1); sample10();
        while (sb_q.size() > 0) begin
            exp_t e; logic [34:0] o;
            e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e.exp) begin
                errors++;
                $display("FAIL %s: got cnt=%h q=%h run=%b split=%b ovf=%b, expected cnt=%h q=%h run=%b split=%b ovf=%b",
                         e.name, o[34:19], o[18:3], o[2], o[1], o[0], e.exp[34:19], e.exp[18:3], e.exp[2], e.exp[1], e.exp[0]);
            end
        end
    endtask

    task automatic test_pause_resume();
        cyc(2);
        expect_push("pause", pack(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0));
        pulse10(1'b1, 1'b0, 1'b0); sample10();
        expect_push("pause_hold50", pack(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0));
        cyc(50); sample10();
        expect_push("resume", pack(16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0));
        pulse10(1'b1, 1'b0, 1'b0); sample10();
        expect_push("resume_6_edges", pack(16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0));
        cyc(6); sample10();
        expect_push("resume_7th_edge", pack(16'h0002, 16'h0002, 1'b1, 1'b0, 1'b0));
        cyc(1); sample10();
        while (sb_q.size() > 0) begin
            exp_t e; logic [34:0] o;
            e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e.exp) begin
                errors++;
                $display("FAIL %s: got cnt=%h q=%h run=%b split=%b ovf=%b, expected cnt=%h q=%h run=%b split=%b ovf=%b",
                         e.name, o[34:19], o[18:3], o[2], o[1], o[0], e.exp[34:19], e.exp[18:3], e.exp[2], e.exp[1], e.exp[0]);
            end
        end
    endtask

    task automatic test_split();
        expect_push("run_to_42", pack(16'h0042, 16'h0042, 1'b1, 1'b0, 1'b0));
        cyc(400); sample10();
        expect_push("lap_capture", pack(16'h0042, 16'h0042, 1'b1, 1'b1, 1'b0));
        pulse10(1'b0, 1'b1, 1'b0); sample10();
        expect_push("split_frozen", pack(16'h0072, 16'h0042, 1'b1, 1'b1, 1'b0));
        cyc(299); sample10();
        expect_push("lap_release", pack(16'h0072, 16'h0072, 1'b1, 1'b0, 1'b0));
        pulse10(1'b0, 1'b1, 1'b0); sample10();
        cyc(8);
        expect_push("tick_with_stop", pack(16'h0073, 16'h0073, 1'b0, 1'b0, 1'b0));
        pulse10(1'b1, 1'b0, 1'b0); sample10();
        while (sb_q.size() > 0) begin
            exp_t e; logic [34:0] o;
            e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e.exp) begin
                errors++;
                $display("FAIL %s: got cnt=%h q=%h run=%b split=%b ovf=%b, expected cnt=%h q=%h run=%b split=%b ovf=%b",
                         e.name, o[34:19], o[18:3], o[2], o[1], o[0], e.exp[34:19], e.exp[18:3], e.exp[2], e.exp[1], e.exp[0]);
            end
        end
    endtask

    task automatic test_command_rules();
        expect_push("lap_in_pause", pack(16'h0073, 16'h0073, 1'b0, 1'b0, 1'b0));
        pulse10(1'b0, 1'b1, 1'b0); sample10();
        expect_push("zero_in_pause", pack(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0));
        pulse10(1'b0, 1'b0, 1'b1); sample10();
        expect_push("lap_in_idle", pack(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0));
        pulse10(1'b0, 1'b1, 1'b0); sample10();
        expect_push("zero_in_idle", pack(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0));
        pulse10(1'b0, 1'b0, 1'b1); sample10();
        expect_push("ss_lap_idle", pack(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0));
        pulse10(1'b1, 1'b1, 1'b0); sample10();
        expect_push("ss_lap_run", pack(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0));
        pulse10(1'b1, 1'b1, 1'b0); sample10();
        while (sb_q.size() > 0) begin
            exp_t e; logic [34:0] o;
            e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e.exp) begin
                errors++;
                $display("FAIL %s: got cnt=%h q=%h run=%b split=%b ovf=%b, expected cnt=%h q=%h run=%b split=%b ovf=%b",
                         e.name, o[34:19], o[18:3], o[2], o[1], o[0], e.exp[34:19], e.exp[18:3], e.exp[2], e.exp[1], e.exp[0]);
            end
        end
    endtask

    task automatic test_carry_overflow();
        expect_push("p1_start", pack(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0));
        pulse1(1'b1, 1'b0, 1'b0); sample1();
        expect_push("p1_0999", pack(16'h0999, 16'h0999, 1'b1, 1'b0, 1'b0));
        cyc(999); sample1();
        expect_push("p1_1000", pack(16'h1000, 16'h1000, 1'b1, 1'b0, 1'b0));
        cyc(1); sample1();
        expect_push("p1_9999", pack(16'h9999, 16'h9999, 1'b1, 1'b0, 1'b0));
        cyc(8999); sample1();
        expect_push("p1_overflow", pack(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1));
        cyc(1); sample1();
        expect_push("p1_zero_in_run", pack(16'h0001, 16'h0001, 1'b1, 1'b0, 1'b1));
        pulse1(1'b0, 1'b0, 1'b1); sample1();
        expect_push("p1_pause", pack(16'h0002, 16'h0002, 1'b0, 1'b0, 1'b1));
        pulse1(1'b1, 1'b0, 1'b0); sample1();
        expect_push("p1_zero_clears", pack(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0));
        pulse1(1'b0, 1'b0, 1'b1); sample1();
        while (sb_q.size() > 0) begin
            exp_t e; logic [34:0] o;
            e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e.exp) begin
                errors++;
                $display("FAIL %s: got cnt=%h q=%h run=%b split=%b ovf=%b, expected cnt=%h q=%h run=%b split=%b ovf=%b",
                         e.name, o[34:19], o[18:3], o[2], o[1], o[0], e.exp[34:19], e.exp[18:3], e.exp[2], e.exp[1], e.exp[0]);
            end
        end
    endtask

    task automatic test_reset_mid_split();
        pulse10(1'b1, 1'b0, 1'b0);
        expect_push("run_to_123", pack(16'h0123, 16'h0123, 1'b1, 1'b0, 1'b0));
        cyc(1229); sample10();
        expect_push("split_at_123", pack(16'h0123, 16'h0123, 1'b1, 1'b1, 1'b0));
        pulse10(1'b0, 1'b1, 1'b0); sample10();
        CLRN = 1'b0;
        expect_push("reset_in_split", pack(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0));
        cyc(1); sample10();
        CLRN = 1'b1;
        while (sb_q.size() > 0) begin
            exp_t e; logic [34:0] o;
            e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e.exp) begin
                errors++;
                $display("FAIL %s: got cnt=%h q=%h run=%b split=%b ovf=%b, expected cnt=%h q=%h run=%b split=%b ovf=%b",
                         e.name, o[34:19], o[18:3], o[2], o[1], o[0], e.exp[34:19], e.exp[18:3], e.exp[2], e.exp[1], e.exp[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_pause_resume();
        test_split();
        test_command_rules();
        test_carry_overflow();
        test_reset_mid_split();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_stopwatch_ctrl.md
# bcd_stopwatch_ctrl

Controller that sequences a 4-digit synchronous BCD counter chain as a stopwatch: start/stop, split (lap) display freeze and zeroing, driven by single-cycle command pulses. A prescaler derives the count tick from the system clock. Digits are cascaded through a synchronous clock-enable chain, so all registers share one clock and no carry is used as a clock. Sits between debounced push-button pulses and a multiplexed 7-segment display driver.

## Interface
Parameters:
- PRESCALE, 10, CLK cycles per count tick; legal range >= 1.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- CLRN  in  1  reset, synchronous and active-low.
- START_STOP  in  1  command pulse, one CLK cycle wide.
- LAP  in  1  command pulse: split freeze / release.
- ZERO  in  1  command pulse: clear count, accepted only in PAUSE.
- CNT  out  16  live BCD count; digit 0 in [3:0], digit 3 in [15:12].
- Q  out  16  displayed BCD value: live or frozen split.
- RUN  out  1  high in RUN and SPLIT.
- SPLIT_ON  out  1  high in SPLIT.
- OVF  out  1  sticky overflow flag.

## Operation
- FSM states: IDLE, RUN, PAUSE, SPLIT. Commands are sampled on the CLK edge. Per-cycle priority is START_STOP > LAP > ZERO, and at most one command acts per cycle. A non-applicable command is ignored with no side effect.
- IDLE: START_STOP -> RUN. LAP and ZERO are ignored.
- RUN: START_STOP -> PAUSE. LAP -> SPLIT, and LATCH <= CNT on the same edge.
- SPLIT: LAP -> RUN, display returns to live. START_STOP -> PAUSE, display returns to live.
- PAUSE: START_STOP -> RUN. ZERO -> IDLE, and on the same edge CNT <= 0, prescaler <= 0, OVF <= 0.
- Prescaler:
  - Counts 0..PRESCALE-1 only while the current state is RUN or SPLIT. It wraps to 0 after PRESCALE-1.
  - TICK = (state in {RUN,SPLIT}) & (prescaler == PRESCALE-1).
  - In PAUSE the prescaler holds its value, so a resume continues the partial period.
  - PRESCALE=1 gives TICK on every RUN/SPLIT cycle.
- Digit chain:
  - CE0 = TICK; CEk = CE(k-1) & (digit k-1 == 9).
  - Each digit steps 0..9 and wraps 9 -> 0 when its CE is high.
  - Digits never hold values 10-15.
- Overflow: CNT 9999 with TICK -> 0000 and OVF <= 1. OVF stays set until ZERO (in PAUSE) or reset. Counting continues after overflow.
- Q = LATCH when in SPLIT, otherwise Q = CNT (combinational mux). CNT keeps counting during SPLIT.
- RUN and SPLIT_ON are decoded from the state register.

## Timing
- Reset (CLRN low at an edge): state=IDLE, CNT=0000, LATCH=0000, prescaler=0, Q=0000, RUN=0, SPLIT_ON=0, OVF=0. Reset overrides all commands and applies mid-count.
- Command latency: a command sampled at edge n changes the state, RUN and SPLIT_ON, visible after edge n.
- First tick: START_STOP at edge 0 from IDLE. The prescaler counts on edges 1..PRESCALE-1, TICK is high in the cycle before edge PRESCALE, and CNT=0001 after edge PRESCALE.
- Split capture: LATCH equals the CNT value present in the cycle LAP was sampled, i.e. before any increment on that edge.
- A tick coinciding with START_STOP in RUN still increments CNT on that edge, because the gate uses the current state. PAUSE then freezes the count.
- Full carry: 0999 + TICK -> 1000 in one edge, with all digits updated simultaneously.

## Test plan
- Reset and first tick: CLRN low for 2 cycles, then START_STOP with PRESCALE=10 -> CNT=0000, RUN=1 after 1 edge; CNT=0001 exactly 10 edges after the START_STOP edge.
- Pause and resume: pause after 3 prescaler counts, hold 50 cycles, resume -> CNT unchanged during pause; next increment after the remaining 7 RUN edges.
- Split freeze: LAP at CNT=0042, run 30 ticks -> Q=0042 and SPLIT_ON=1 while CNT=0072; second LAP -> Q=CNT on the next cycle.
- Carry and overflow (PRESCALE=1): run to 0999 -> next edge 1000; continue to 9999 -> next edge 0000 with OVF=1; ZERO while in RUN is ignored (OVF stays 1).
- Command rules: ZERO in PAUSE -> IDLE, CNT=0000, OVF=0; START_STOP+LAP in the same cycle in RUN -> PAUSE, not SPLIT; LAP in IDLE or PAUSE -> no change.
- Reset mid-SPLIT at CNT=0123 -> all outputs at reset values on the next cycle.
